ex_pipe_ctl: RTL and testbench

//  Parametrised pipeline sequencing controller for the JX2 core: fetch PC, stall/hold, interlock, branch flush.

---
 rtl/ex_pipe_ctl.sv | 142 ++++++++++++++
 tb/tb_ex_pipe_ctl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_pipe_ctl.sv
// Pipeline sequencing controller: fetch PC, front/back hold, EX interlock,
// branch flush masking, redirects held pending across stalls, and stall/flush counters.
module ex_pipe_ctl #(
    parameter int               NSTG    = 3,
    parameter int               NBRA    = 2,
    parameter int               NHOLD   = 3,
    parameter int               RW      = 6,
    parameter int               PCW     = 32,
    parameter int               FLW     = 8,
    parameter int               FLDEPTH = 3,
    parameter logic [RW-1:0]    ZZR     = {RW{1'b1}},
    parameter logic [PCW-1:0]   RST_PC  = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NHOLD-1:0]    holdSrc,
    input  logic [1:0]          ifStep,
    input  logic [RW-1:0]       srcRs,
    input  logic [RW-1:0]       srcRt,
    input  logic [RW-1:0]       srcRm,
    input  logic                srcRmEn,
    input  logic [NSTG*RW-1:0]  stDstId,
    input  logic [NSTG-1:0]     stDstLate,
    input  logic [NBRA-1:0]     braVld,
    input  logic [NBRA*PCW-1:0] braPc,
    input  logic                preBra,
    input  logic [PCW-1:0]      preBraPc,
    output logic [PCW-1:0]      pcOut,
    output logic                holdFront,
    output logic                holdBack,
    output logic                killEx1,
    output logic [FLW-1:0]      flushMask,
    output logic [31:0]         cntIlk,
    output logic [31:0]         cntFlush
);

    localparam logic [FLW-1:0] MASK_FULL = FLW'((1 << FLDEPTH) - 1);
    localparam logic [FLW-1:0] MASK_PRE  = FLW'(4);

    logic [PCW-1:0] pcReg, pcNext;
    logic [FLW-1:0] maskReg, maskNext;
    logic           pendVldReg, pendVldNext;
    logic [PCW-1:0] pendPcReg, pendPcNext;
    logic [31:0]    cntIlkReg, cntIlkNext;
    logic [31:0]    cntFlushReg, cntFlushNext;

    logic [NSTG-1:0] stgHit;
    logic            ilk;
    logic            backReq;
    logic            frontStall;
    logic            braAny;
    logic [PCW-1:0]  braTgt;

    // A late EX result blocks ID2 only when one of its live sources names it.
    for (genvar gi = 0; gi < NSTG; gi++) begin : g_stg
        logic [RW-1:0] dstId;
        assign dstId = stDstId[gi*RW +: RW];
        assign stgHit[gi] = stDstLate[gi] && (dstId != ZZR) &&
                            ((dstId == srcRs) || (dstId == srcRt) ||
                             (srcRmEn && (dstId == srcRm)));
    end

    assign ilk        = |stgHit;
    assign backReq    = |holdSrc;
    assign frontStall = backReq | ilk;

    // Later (higher-index) redirect sources come from older-in-flow stages and win.
    always_comb begin
        braAny = 1'b0;
        braTgt = '0;
        for (int i = 0; i < NBRA; i++) begin
            if (braVld[i]) begin
                braAny = 1'b1;
                braTgt = braPc[i*PCW +: PCW];
            end
        end
    end

    always_comb begin
        pcNext       = pcReg;
        maskNext     = maskReg;
        pendVldNext  = pendVldReg;
        pendPcNext   = pendPcReg;
        cntIlkNext   = cntIlkReg;
        cntFlushNext = cntFlushReg;

        if (ilk && !backReq)
            cntIlkNext = cntIlkReg + 32'd1;

        if (frontStall) begin
            if (braAny) begin
                pendVldNext = 1'b1;
                pendPcNext  = braTgt;
            end
        end else if (braAny) begin
            pcNext       = braTgt;
            maskNext     = MASK_FULL;
            pendVldNext  = 1'b0;
            cntFlushNext = cntFlushReg + 32'd1;
        end else if (pendVldReg) begin
            pcNext       = pendPcReg;
            maskNext     = MASK_FULL;
            pendVldNext  = 1'b0;
            cntFlushNext = cntFlushReg + 32'd1;
        end else if (preBra) begin
            // Only the fall-through fetch already in IF needs killing.
            pcNext   = preBraPc;
            maskNext = (maskReg >> 1) | MASK_PRE;
        end else begin
            pcNext   = pcReg + PCW'({ifStep, 1'b0});
            maskNext = maskReg >> 1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pcReg       <= RST_PC;
            maskReg     <= MASK_FULL;
            pendVldReg  <= 1'b0;
            pendPcReg   <= '0;
            cntIlkReg   <= '0;
            cntFlushReg <= '0;
        end else begin
            pcReg       <= pcNext;
            maskReg     <= maskNext;
            pendVldReg  <= pendVldNext;
            pendPcReg   <= pendPcNext;
            cntIlkReg   <= cntIlkNext;
            cntFlushReg <= cntFlushNext;
        end
    end

    // Holds are suppressed while in reset so downstream stages see a clean bubble.
    assign holdBack  = !reset && backReq;
    assign holdFront = !reset && frontStall;
    assign killEx1   = reset || maskReg[0] || (ilk && !backReq);
    assign pcOut     = pcReg;
    assign flushMask = maskReg;
    assign cntIlk    = cntIlkReg;
    assign cntFlush  = cntFlushReg;

endmodule

// File: tb/tb_ex_pipe_ctl.sv
// Bench for ex_pipe_ctl: directed scenarios with fixed expectations, then random
// traffic against a cycle-level behavioural model of the sequencing rules.
module tb_ex_pipe_ctl;

    localparam int NSTG = 3, NBRA = 2, NHOLD = 3, RW = 6, PCW = 32, FLW = 8;
    localparam logic [RW-1:0] ZZR = 6'h3F;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [NHOLD-1:0]    holdSrc = '0;
    logic [1:0]          ifStep = '0;
    logic [RW-1:0]       srcRs = '0, srcRt = '0, srcRm = '0;
    logic                srcRmEn = 1'b0;
    logic [NSTG*RW-1:0]  stDstId = '0;
    logic [NSTG-1:0]     stDstLate = '0;
    logic [NBRA-1:0]     braVld = '0;
    logic [NBRA*PCW-1:0] braPc = '0;
    logic                preBra = 1'b0;
    logic [PCW-1:0]      preBraPc = '0;
    logic [PCW-1:0]      pcOut;
    logic                holdFront, holdBack, killEx1;
    logic [FLW-1:0]      flushMask;
    logic [31:0]         cntIlk, cntFlush;

    int testsRun = 0;
    int testsFailed = 0;

    // Behavioural model state
    logic [31:0] mPc = '0;
    int          mMask = 7;
    bit          mPend = 0;
    logic [31:0] mPendPc = '0;
    logic [31:0] mCntIlk = '0, mCntFlush = '0;

    ex_pipe_ctl dut (
        .clock(clock), .reset(reset), .holdSrc(holdSrc), .ifStep(ifStep),
        .srcRs(srcRs), .srcRt(srcRt), .srcRm(srcRm), .srcRmEn(srcRmEn),
        .stDstId(stDstId), .stDstLate(stDstLate), .braVld(braVld), .braPc(braPc),
        .preBra(preBra), .preBraPc(preBraPc), .pcOut(pcOut), .holdFront(holdFront),
        .holdBack(holdBack), .killEx1(killEx1), .flushMask(flushMask),
        .cntIlk(cntIlk), .cntFlush(cntFlush)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit modelIlk();
        for (int s = 0; s < NSTG; s++) begin
            logic [RW-1:0] id;
            id = stDstId[s*RW +: RW];
            if (stDstLate[s] && id != ZZR &&
                (id == srcRs || id == srcRt || (srcRmEn && id == srcRm)))
                return 1;
        end
        return 0;
    endfunction

    // Advance the model by one clock using the present inputs, then let the DUT
    // take the same edge; returns at the following falling edge.
    task automatic tick();
        bit hasBra, stall;
        logic [31:0] tgt;
        hasBra = 0;
        tgt = '0;
        for (int b = NBRA - 1; b >= 0 && !hasBra; b--) begin
            if (braVld[b]) begin
                hasBra = 1;
                tgt = braPc[b*PCW +: PCW];
            end
        end
        stall = (holdSrc != 0) || modelIlk();
        if (reset) begin
            mPc = 0; mMask = 7; mPend = 0; mCntIlk = 0; mCntFlush = 0;
        end else begin
            if (modelIlk() && holdSrc == 0) mCntIlk = mCntIlk + 1;
            if (stall) begin
                if (hasBra) begin mPend = 1; mPendPc = tgt; end
            end else if (hasBra || mPend) begin
                mPc = hasBra ? tgt : mPendPc;
                mMask = 7; mPend = 0; mCntFlush = mCntFlush + 1;
            end else if (preBra) begin
                mPc = preBraPc; mMask = (mMask / 2) | 4;
            end else begin
                mPc = mPc + 32'(ifStep) * 2; mMask = mMask / 2;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        logic [31:0] expPc [3] = '{32'd0, 32'd4, 32'd8};
        reset = 1; holdSrc = 3'b111;
        tick(); tick();
        #1;
        testsRun++;
        if (holdBack !== 1'b0 || holdFront !== 1'b0 || killEx1 !== 1'b1) begin
            testsFailed++;
            $display("FAIL reset_comb: got hb=%b hf=%b kill=%b want 0 0 1", holdBack, holdFront, killEx1);
        end
        tick();
        reset = 0; holdSrc = '0; ifStep = 2'd2;
        #1;
        testsRun++;
        if (flushMask !== 8'h07 || cntIlk !== 0 || cntFlush !== 0) begin
            testsFailed++;
            $display("FAIL reset_state: got mask=%h ilk=%0d fl=%0d want 07 0 0", flushMask, cntIlk, cntFlush);
        end
        for (int k = 0; k < 4; k++) begin
            testsRun++;
            if (k < 3 && pcOut !== expPc[k]) begin
                testsFailed++;
                $display("FAIL reset_pc%0d: got %h want %h", k, pcOut, expPc[k]);
            end
            testsRun++;
            if (killEx1 !== (k < 3)) begin
                testsFailed++;
                $display("FAIL reset_kill%0d: got %b want %b", k, killEx1, k < 3);
            end
            tick();
            #1;
        end
    endtask

    task automatic test_interlock();
        logic [31:0] c0, p0;
        stDstLate = 3'b001; stDstId = '0; stDstId[RW-1:0] = 6'd5; srcRt = 6'd5; ifStep = 2'd2;
        #1;
        c0 = cntIlk; p0 = pcOut;
        testsRun++;
        if (holdFront !== 1'b1 || holdBack !== 1'b0 || killEx1 !== 1'b1) begin
            testsFailed++;
            $display("FAIL ilk_comb: got hf=%b hb=%b kill=%b want 1 0 1", holdFront, holdBack, killEx1);
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            testsRun++;
            if (cntIlk !== c0 + 32'(k) || pcOut !== p0) begin
                testsFailed++;
                $display("FAIL ilk_cycle%0d: got cnt=%0d pc=%h want %0d %h", k, cntIlk, pcOut, c0 + 32'(k), p0);
            end
        end
        stDstId[RW-1:0] = ZZR; srcRt = ZZR;
        #1;
        testsRun++;
        if (holdFront !== 1'b0 || killEx1 !== 1'b0) begin
            testsFailed++;
            $display("FAIL ilk_zzr: got hf=%b kill=%b want 0 0", holdFront, killEx1);
        end
        tick();
        testsRun++;
        if (cntIlk !== c0 + 32'd3 || pcOut !== p0 + 32'd4) begin
            testsFailed++;
            $display("FAIL ilk_zzr_adv: got cnt=%0d pc=%h want %0d %h", cntIlk, pcOut, c0 + 32'd3, p0 + 32'd4);
        end
        stDstLate = '0; stDstId = '0; srcRt = '0;
    endtask

    task automatic test_redirect_both();
        braVld = 2'b11; braPc = {32'h200, 32'h100}; preBra = 1; preBraPc = 32'h40;
        tick();
        braVld = '0; preBra = 0;
        testsRun++;
        if (pcOut !== 32'h200 || flushMask !== 8'h07 || cntFlush !== 32'd1) begin
            testsFailed++;
            $display("FAIL redirect: got pc=%h mask=%h fl=%0d want 200 07 1", pcOut, flushMask, cntFlush);
        end
    endtask

    task automatic test_pending();
        logic [31:0] p0;
        ifStep = 2'd2; holdSrc = 3'b010;
        p0 = pcOut;
        braVld = 2'b01; braPc = {32'h0, 32'h300};
        for (int k = 0; k < 3; k++) begin
            #1;
            testsRun++;
            if (holdFront !== 1'b1 || holdBack !== 1'b1) begin
                testsFailed++;
                $display("FAIL pend_hold%0d: got hf=%b hb=%b want 1 1", k, holdFront, holdBack);
            end
            tick();
            braVld = '0;
            testsRun++;
            if (pcOut !== p0) begin
                testsFailed++;
                $display("FAIL pend_stay%0d: got %h want %h", k, pcOut, p0);
            end
        end
        holdSrc = '0;
        tick();
        testsRun++;
        if (pcOut !== 32'h300 || cntFlush !== 32'd2 || flushMask !== 8'h07) begin
            testsFailed++;
            $display("FAIL pend_apply: got pc=%h fl=%0d mask=%h want 300 2 07", pcOut, cntFlush, flushMask);
        end
        tick();
        testsRun++;
        if (pcOut !== 32'h304 || cntFlush !== 32'd2) begin
            testsFailed++;
            $display("FAIL pend_once: got pc=%h fl=%0d want 304 2", pcOut, cntFlush);
        end
    endtask

    task automatic test_prebra();
        logic kExp [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        tick(); tick();
        testsRun++;
        if (flushMask !== 8'h00) begin
            testsFailed++;
            $display("FAIL prebra_pre: got mask=%h want 00", flushMask);
        end
        preBra = 1; preBraPc = 32'h40;
        tick();
        preBra = 0;
        testsRun++;
        if (pcOut !== 32'h40 || flushMask !== 8'h04) begin
            testsFailed++;
            $display("FAIL prebra: got pc=%h mask=%h want 40 04", pcOut, flushMask);
        end
        for (int k = 0; k < 4; k++) begin
            #1;
            testsRun++;
            if (killEx1 !== kExp[k]) begin
                testsFailed++;
                $display("FAIL prebra_kill%0d: got %b want %b", k, killEx1, kExp[k]);
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        braVld = 2'b10; braPc = {32'hFFFF_FFFC, 32'h0};
        tick();
        braVld = '0; ifStep = 2'd3;
        tick();
        testsRun++;
        if (pcOut !== 32'h2) begin
            testsFailed++;
            $display("FAIL wrap: got %h want 00000002", pcOut);
        end
        ifStep = 2'd0;
        tick();
        testsRun++;
        if (pcOut !== 32'h2) begin
            testsFailed++;
            $display("FAIL refetch: got %h want 00000002", pcOut);
        end
    endtask

    task automatic test_reset_mid_stall();
        holdSrc = 3'b100; braVld = 2'b01; braPc = {32'h0, 32'h500};
        tick();
        braVld = '0;
        tick();
        reset = 1;
        #1;
        testsRun++;
        if (holdBack !== 1'b0 || holdFront !== 1'b0 || killEx1 !== 1'b1) begin
            testsFailed++;
            $display("FAIL rst_stall_comb: got hb=%b hf=%b kill=%b want 0 0 1", holdBack, holdFront, killEx1);
        end
        tick();
        reset = 0; holdSrc = '0; ifStep = 2'd0;
        testsRun++;
        if (pcOut !== 32'h0 || cntFlush !== 0 || flushMask !== 8'h07) begin
            testsFailed++;
            $display("FAIL rst_stall: got pc=%h fl=%0d mask=%h want 0 0 07", pcOut, cntFlush, flushMask);
        end
        tick();
        testsRun++;
        if (pcOut !== 32'h0 || cntFlush !== 0) begin
            testsFailed++;
            $display("FAIL rst_stall_pend: got pc=%h fl=%0d want 0 0", pcOut, cntFlush);
        end
    endtask

    function automatic logic [RW-1:0] pickId();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? ZZR : RW'(r + 1);
    endfunction

    task automatic test_random();
        bit ilkE, hbE;
        for (int n = 0; n < 500; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            for (int h = 0; h < NHOLD; h++) holdSrc[h] = ($urandom_range(0, 7) == 0);
            ifStep = 2'($urandom_range(0, 3));
            srcRs = pickId(); srcRt = pickId(); srcRm = pickId();
            srcRmEn = 1'($urandom_range(0, 1));
            for (int s = 0; s < NSTG; s++) stDstId[s*RW +: RW] = pickId();
            stDstLate = NSTG'($urandom_range(0, 7)) & NSTG'($urandom_range(0, 7));
            for (int b = 0; b < NBRA; b++) begin
                braVld[b] = ($urandom_range(0, 9) == 0);
                braPc[b*PCW +: PCW] = $urandom() & 32'hFFFF_FFFE;
            end
            preBra = ($urandom_range(0, 5) == 0);
            preBraPc = $urandom() & 32'hFFFF_FFFE;
            #1;
            ilkE = modelIlk();
            hbE = (holdSrc != 0);
            testsRun++;
            if (holdBack !== (!reset && hbE) || holdFront !== (!reset && (hbE || ilkE)) ||
                killEx1 !== (reset || mMask[0] || (ilkE && !hbE))) begin
                testsFailed++;
                $display("FAIL rand_comb%0d: got hb=%b hf=%b kill=%b want %b %b %b", n, holdBack, holdFront,
                         killEx1, !reset && hbE, !reset && (hbE || ilkE), reset || mMask[0] || (ilkE && !hbE));
            end
            tick();
            testsRun++;
            if (pcOut !== mPc || flushMask !== FLW'(mMask) || cntIlk !== mCntIlk || cntFlush !== mCntFlush) begin
                testsFailed++;
                $display("FAIL rand_state%0d: got pc=%h mask=%h ilk=%0d fl=%0d want %h %h %0d %0d", n, pcOut,
                         flushMask, cntIlk, cntFlush, mPc, FLW'(mMask), mCntIlk, mCntFlush);
            end
        end
        reset = 0; holdSrc = '0; braVld = '0; preBra = 0; stDstLate = '0;
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_interlock();
        test_redirect_both();
        test_pending();
        test_prebra();
        test_wrap();
        test_reset_mid_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
